serial_adder_driver: RTL and testbench

//  Initiator for the task2 serial-adder handshake (load/A/B/start -> sum/done).
//  - Accepts operand pairs on a valid/ready stream.
//  - Sequences load/start into the adder, waits for done and captures sum.
//  - Returns each result on a valid/ready stream, with a timeout error flag.
//  - Sits between a job source (CPU or test sequencer) and one task2 instance.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_driver_timeout_timer.sv | 44 ++++
 rtl/serial_adder_driver.sv | 152 +++++++++++++++
 tb/tb_serial_adder_driver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//   Shared types and defaults for the serial-adder driver slice.
//   - SA_W        : default operand/sum width of the task2 adder
//   - drv_state_t : driver FSM states
// ---------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int unsigned SA_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        HOLD
    } drv_state_t;

endpackage

// File: rtl/serial_adder_driver_timeout_timer.sv
// ---------------------------------------------------------------------------
// timeout_timer
//   Cycle counter bounding how long the driver waits for the adder.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clr        : synchronous clear to 0 (has priority over en)
//     en         : count up by one
//     expired    : count has reached TIMEOUT-1
// ---------------------------------------------------------------------------
module timeout_timer #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned TW = $clog2(TIMEOUT);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/serial_adder_driver.sv
// ---------------------------------------------------------------------------
// serial_adder_driver
//   Initiator for the task2 serial adder. Takes operand pairs from a
//   valid/ready stream, sequences load/start into the adder, waits for a
//   rising edge of done and returns the sum (or a timeout error) on an
//   output valid/ready stream. One job in flight at a time.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     in_valid/in_ready   : operand stream handshake (in_ready = IDLE)
//     in_a, in_b          : operands
//     load, start         : adder control, decoded from registered state
//     A, B                : registered operands to the adder
//     sum, done           : adder result and level done flag
//     out_valid/out_ready : result stream handshake
//     out_sum, out_err    : captured sum (0 on timeout), timeout flag
//     job_cnt             : results delivered, wraps
// ---------------------------------------------------------------------------
module serial_adder_driver
    import serial_adder_pkg::*;
#(
    parameter int unsigned W       = SA_W,
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             load,
    output logic             start,
    output logic [W-1:0]     A,
    output logic [W-1:0]     B,
    input  logic [W-1:0]     sum,
    input  logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_err,
    output logic [CNT_W-1:0] job_cnt
);

    drv_state_t       state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     out_sum_q, out_sum_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] job_cnt_q, job_cnt_d;
    logic             done_q, done_d;

    logic tmr_clr;
    logic tmr_en;
    logic tmr_expired;
    logic done_rise;

    timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Only a fresh rising edge counts: a done left high by the previous job
    // must not be mistaken for this job's result.
    assign done_rise = done & ~done_q;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        out_sum_d = out_sum_q;
        out_err_d = out_err_q;
        job_cnt_d = job_cnt_q;
        done_d    = done;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = START;
            end
            START: begin
                tmr_clr = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                tmr_en = 1'b1;
                // done rise is tested first so it wins over a same-cycle expiry
                if (done_rise) begin
                    out_sum_d = sum;
                    out_err_d = 1'b0;
                    state_d   = HOLD;
                end else if (tmr_expired) begin
                    out_sum_d = '0;
                    out_err_d = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    job_cnt_d = job_cnt_q + 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            out_sum_q <= '0;
            out_err_q <= 1'b0;
            job_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            out_sum_q <= out_sum_d;
            out_err_q <= out_err_d;
            job_cnt_q <= job_cnt_d;
            done_q    <= done_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign load      = (state_q == LOAD) || (state_q == START);
    assign start     = (state_q == START);
    assign out_valid = (state_q == HOLD);
    assign A         = a_q;
    assign B         = b_q;
    assign out_sum   = out_sum_q;
    assign out_err   = out_err_q;
    assign job_cnt   = job_cnt_q;

endmodule

// File: tb/tb_serial_adder_driver.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_driver
//   Drives serial_adder_driver against a scripted adder model and checks
//   every delivered result against sums computed from the issued operands.
// ---------------------------------------------------------------------------
module tb_serial_adder_driver;

    localparam int unsigned W       = 4;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CNT_W   = 8;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_a      = '0;
    logic [W-1:0]     in_b      = '0;
    logic             load;
    logic             start;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [W-1:0]     sum       = '0;
    logic             done      = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_sum;
    logic             out_err;
    logic [CNT_W-1:0] job_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    // scripted adder model controls
    int unsigned m_lat  = 1;
    bit          m_hang = 1'b0;
    bit          m_keep = 1'b0;
    bit          m_busy = 1'b0;
    int unsigned m_cnt  = 0;
    logic [W-1:0] m_res = '0;

    serial_adder_driver #(
        .W       (W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .load      (load),
        .start     (start),
        .A         (A),
        .B         (B),
        .sum       (sum),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_err   (out_err),
        .job_cnt   (job_cnt)
    );

    always #5 clk = ~clk;

    // Adder model: updates on negedge. done rises m_lat cycles after start;
    // with m_keep a stale done survives load and drops one cycle before the
    // fresh rise; with m_hang done never rises.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done   = 1'b0;
            m_busy = 1'b0;
            m_cnt  = 0;
        end else begin
            if (load && !start && !m_keep) done = 1'b0;
            if (start) begin
                m_busy = 1'b1;
                m_cnt  = m_lat;
                m_res  = A + B;
            end else if (m_busy) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    if (!m_hang) begin
                        done = 1'b1;
                        sum  = m_res;
                    end
                end else if (m_cnt == 1) begin
                    done = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic run_job(input int unsigned a, input int unsigned b, input int unsigned lat,
                           input bit hang, input bit keep, input int unsigned hold);
        bit          exp_err;
        int unsigned exp_sum;
        int unsigned exp_lat;
        bit          got_valid;
        logic [W-1:0] held_sum;

        exp_err  = hang || (lat > TIMEOUT);
        exp_sum  = exp_err ? 0 : (a + b) % (1 << W);
        exp_lat  = exp_err ? TIMEOUT + 3 : lat + 3;
        got_valid = 1'b0;

        @(negedge clk);
        m_lat     = lat;
        m_hang    = hang;
        m_keep    = keep;
        out_ready = (hold == 0);
        in_a      = W'(a);
        in_b      = W'(b);
        in_valid  = 1'b1;
        check("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);

        for (int n = 1; n <= int'(TIMEOUT) + 8; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("load_c1", load, 1);
                check("start_c1", start, 0);
                check("in_ready_busy", in_ready, 0);
                check("reg_A", A, a);
                check("reg_B", B, b);
            end
            if (n == 2) begin
                check("load_c2", load, 1);
                check("start_c2", start, 1);
            end
            if (n == 3) begin
                check("load_c3", load, 0);
                check("start_c3", start, 0);
            end
            if (out_valid) begin
                check("latency", n, exp_lat);
                got_valid = 1'b1;
                break;
            end
        end

        if (!got_valid) begin
            check("out_valid_seen", 0, 1);
        end else begin
            check("out_sum", out_sum, exp_sum);
            check("out_err", out_err, exp_err);
            check("job_cnt_hold", job_cnt, exp_cnt);
            held_sum = out_sum;
            for (int i = 0; i < int'(hold); i++) begin
                in_valid = (i % 2 == 0);
                @(negedge clk);
                check("hold_valid", out_valid, 1);
                check("hold_sum", out_sum, held_sum);
                check("hold_in_ready", in_ready, 0);
                check("hold_no_load", load, 0);
            end
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        exp_cnt = exp_cnt + 1'b1;
        check("retire_valid", out_valid, 0);
        check("retire_in_ready", in_ready, 1);
        check("job_cnt", job_cnt, exp_cnt);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_load", load, 0);
        check("rst_start", start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_err", out_err, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_job_cnt", job_cnt, 0);
        rst_n = 1'b1;

        // back-to-back jobs
        run_job(4, 5, 1, 0, 0, 0);
        run_job(3, 7, 2, 0, 0, 0);
        run_job(1, 3, 1, 0, 0, 0);
        check("job_cnt_3", job_cnt, 3);
        // 4-bit wrap
        run_job(9, 8, 3, 0, 0, 0);
        // adder hangs -> timeout, then a normal job
        run_job(5, 5, 1, 1, 0, 0);
        run_job(2, 2, 1, 0, 0, 0);
        // stale done from 4+5=9 must not be captured
        run_job(4, 5, 2, 0, 0, 0);
        run_job(2, 4, 3, 0, 1, 0);
        // backpressure in HOLD
        run_job(7, 6, 2, 0, 0, 10);
        // done rising on the expiry cycle wins; one cycle later is a timeout
        run_job(1, 1, TIMEOUT, 0, 0, 0);
        run_job(1, 1, TIMEOUT + 1, 0, 0, 0);

        // async reset while waiting on a hung adder
        @(negedge clk);
        m_hang   = 1'b1;
        m_keep   = 1'b0;
        m_lat    = 1;
        in_a     = 4'd6;
        in_b     = 4'd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        check("mid_rst_load", load, 0);
        check("mid_rst_start", start, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_job_cnt", job_cnt, 0);
        exp_cnt = '0;
        run_job(4, 5, 1, 0, 0, 0);

        // random jobs; count passes 2^CNT_W to exercise job_cnt wrap
        for (int j = 0; j < 260; j++) begin
            run_job($urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(1, TIMEOUT + 2), ($urandom_range(0, 9) == 0),
                    0, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
